// File: rtl/sdrc_mport_arb.sv
// rtl/sdrc_mport_arb.sv - multi-port Wishbone front end sharing one sdrc_core app request interface
//
// Ports:
//   wb_clk_i, wb_rst_i      clock (also clocks the app side), synchronous active-high reset
//   wb_cyc_i/stb_i/we_i     per-port cycle, strobe, write
//   wb_addr_i               per-port byte address, 26 bits per port
//   wb_dat_i, wb_sel_i      per-port write data and byte enables
//   wb_cti_i                per-port cycle type (3'b010 = incrementing burst)
//   wb_ack_o, wb_dat_o      per-port acknowledge, shared read data
//   app_req*                request, direction, word address and length to the core
//   app_req_ack             core accepted the request
//   app_wr_next_req         core takes one write word this cycle
//   app_wr_data/en_n        write data and active-low byte enables
//   app_rd_valid/last_rd    read word valid, last word of burst
//   app_rd_data             read data from the core
//   gnt_o                   one-hot current grant
module sdrc_mport_arb #(
   parameter int NPORT     = 4,
   parameter int dw        = 32,
   parameter int bl        = 9,
   parameter int BURST_LEN = 8
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   input  logic [NPORT-1:0]      wb_cyc_i,
   input  logic [NPORT-1:0]      wb_stb_i,
   input  logic [NPORT-1:0]      wb_we_i,
   input  logic [NPORT*26-1:0]   wb_addr_i,
   input  logic [NPORT*dw-1:0]   wb_dat_i,
   input  logic [NPORT*dw/8-1:0] wb_sel_i,
   input  logic [NPORT*3-1:0]    wb_cti_i,
   output logic [NPORT-1:0]      wb_ack_o,
   output logic [dw-1:0]         wb_dat_o,
   output logic                  app_req,
   output logic                  app_req_wr_n,
   output logic [24:0]           app_req_addr,
   output logic [bl-1:0]         app_req_len,
   input  logic                  app_req_ack,
   input  logic                  app_wr_next_req,
   output logic [dw-1:0]         app_wr_data,
   output logic [dw/8-1:0]       app_wr_en_n,
   input  logic                  app_rd_valid,
   input  logic                  app_last_rd,
   input  logic [dw-1:0]         app_rd_data,
   output logic [NPORT-1:0]      gnt_o
);

   localparam int IW = (NPORT > 1) ? $clog2(NPORT) : 1;

   typedef enum logic [1:0] {IDLE, REQ, WDAT, RDAT} state_t;

   state_t            state, state_nxt;
   logic [NPORT-1:0]  gnt, gnt_nxt;
   logic [IW-1:0]     last_gnt, last_gnt_nxt;
   logic              we_r, we_nxt;
   logic [23:0]       addr_r, addr_nxt;
   logic [2:0]        cti_r, cti_nxt;
   logic [bl-1:0]     cnt, cnt_nxt;
   logic [bl-1:0]     req_len;

   logic              found;
   logic [IW-1:0]     pick;
   logic [IW-1:0]     cand;

   // last_gnt doubles as the index of the granted port while a transfer is active
   logic              g_stb;
   logic [dw-1:0]     g_dat;
   logic [dw/8-1:0]   g_sel;

   assign g_stb   = wb_stb_i[last_gnt];
   assign g_dat   = wb_dat_i[int'(last_gnt)*dw +: dw];
   assign g_sel   = wb_sel_i[int'(last_gnt)*(dw/8) +: dw/8];
   assign req_len = (cti_r == 3'b010) ? bl'(BURST_LEN) : bl'(1);
   assign gnt_o   = gnt;

   // Round-robin search: start one past the previous winner and wrap
   always_comb begin
      found = 1'b0;
      pick  = last_gnt;
      cand  = '0;
      for (int k = 1; k <= NPORT; k++) begin
         cand = IW'((int'(last_gnt) + k) % NPORT);
         if (!found && wb_cyc_i[cand] && wb_stb_i[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state    <= IDLE;
         gnt      <= '0;
         last_gnt <= IW'(NPORT-1);
         we_r     <= 1'b0;
         addr_r   <= '0;
         cti_r    <= '0;
         cnt      <= '0;
      end else begin
         state    <= state_nxt;
         gnt      <= gnt_nxt;
         last_gnt <= last_gnt_nxt;
         we_r     <= we_nxt;
         addr_r   <= addr_nxt;
         cti_r    <= cti_nxt;
         cnt      <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      gnt_nxt      = gnt;
      last_gnt_nxt = last_gnt;
      we_nxt       = we_r;
      addr_nxt     = addr_r;
      cti_nxt      = cti_r;
      cnt_nxt      = cnt;

      app_req      = 1'b0;
      app_req_wr_n = 1'b0;
      app_req_addr = '0;
      app_req_len  = '0;
      app_wr_data  = '0;
      app_wr_en_n  = '1;
      wb_ack_o     = '0;
      wb_dat_o     = '0;

      case (state)
         IDLE: begin
            gnt_nxt = '0;
            if (found) begin
               gnt_nxt[pick] = 1'b1;
               last_gnt_nxt  = pick;
               we_nxt        = wb_we_i[pick];
               addr_nxt      = wb_addr_i[int'(pick)*26+2 +: 24];
               cti_nxt       = wb_cti_i[int'(pick)*3 +: 3];
               state_nxt     = REQ;
            end
         end
         REQ: begin
            app_req      = 1'b1;
            app_req_wr_n = ~we_r;
            app_req_addr = {1'b0, addr_r};
            app_req_len  = req_len;
            if (app_req_ack) begin
               cnt_nxt   = req_len;
               state_nxt = we_r ? WDAT : RDAT;
            end
         end
         WDAT: begin
            app_wr_data = g_dat;
            // A strobe-less beat still has to be fed to the core, so it goes out masked
            app_wr_en_n = g_stb ? ~g_sel : '1;
            wb_ack_o[last_gnt] = app_wr_next_req & g_stb;
            if (app_wr_next_req) begin
               cnt_nxt = cnt - bl'(1);
               if (cnt <= bl'(1)) begin
                  cnt_nxt   = '0;
                  gnt_nxt   = '0;
                  state_nxt = IDLE;
               end
            end
         end
         RDAT: begin
            wb_dat_o = app_rd_data;
            wb_ack_o[last_gnt] = app_rd_valid & g_stb;
            if (app_rd_valid) begin
               cnt_nxt = cnt - bl'(1);
               if (cnt <= bl'(1) || app_last_rd) begin
                  cnt_nxt   = '0;
                  gnt_nxt   = '0;
                  state_nxt = IDLE;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_sdrc_mport_arb.sv
// tb/tb_sdrc_mport_arb.sv - self-checking bench for sdrc_mport_arb
module tb_sdrc_mport_arb;

   localparam int NP   = 4;
   localparam int DW   = 32;
   localparam int BL   = 9;
   localparam int BLEN = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NP-1:0]     cyc = '0, stb = '0, we = '0;
   logic [NP*26-1:0]  addr = '0;
   logic [NP*DW-1:0]  dat = '0;
   logic [NP*DW/8-1:0] sel = '0;
   logic [NP*3-1:0]   cti = '0;
   logic [NP-1:0]     wb_ack;
   logic [DW-1:0]     wb_dat;
   logic              app_req, app_req_wr_n;
   logic [24:0]       app_req_addr;
   logic [BL-1:0]     app_req_len;
   logic              app_req_ack = 1'b0;
   logic              app_wr_next_req = 1'b0;
   logic [DW-1:0]     app_wr_data;
   logic [DW/8-1:0]   app_wr_en_n;
   logic              app_rd_valid = 1'b0;
   logic              app_last_rd = 1'b0;
   logic [DW-1:0]     app_rd_data = '0;
   logic [NP-1:0]     gnt;

   sdrc_mport_arb #(.NPORT(NP), .dw(DW), .bl(BL), .BURST_LEN(BLEN)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
      .wb_addr_i(addr), .wb_dat_i(dat), .wb_sel_i(sel), .wb_cti_i(cti),
      .wb_ack_o(wb_ack), .wb_dat_o(wb_dat),
      .app_req(app_req), .app_req_wr_n(app_req_wr_n),
      .app_req_addr(app_req_addr), .app_req_len(app_req_len),
      .app_req_ack(app_req_ack), .app_wr_next_req(app_wr_next_req),
      .app_wr_data(app_wr_data), .app_wr_en_n(app_wr_en_n),
      .app_rd_valid(app_rd_valid), .app_last_rd(app_last_rd),
      .app_rd_data(app_rd_data), .gnt_o(gnt)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;
   int ack_cnt [NP];
   bit started = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      else passed++;
   endtask

   // Transaction-level model: which port owns the app interface, in which phase,
   // and how many words are still owed
   int          m_phase = 0;   // 0 idle, 1 requesting, 2 writing, 3 reading
   int          m_port  = -1;
   int          m_last  = NP-1;
   int          m_left  = 0;
   int          m_len   = 0;
   bit          m_we    = 0;
   logic [25:0] m_addr  = '0;

   initial begin
      for (int p = 0; p < NP; p++) ack_cnt[p] = 0;
      forever begin
         @(negedge clk);
         if (started) begin
            logic [NP-1:0]   e_ack;
            logic [DW/8-1:0] e_en;
            e_ack = '0;
            e_en  = '1;
            if (m_phase == 2 && app_wr_next_req && stb[m_port]) e_ack[m_port] = 1'b1;
            if (m_phase == 3 && app_rd_valid && stb[m_port])    e_ack[m_port] = 1'b1;
            if (m_phase == 2 && stb[m_port]) e_en = ~sel[m_port*4 +: 4];
            chk("gnt_o", gnt, (m_port >= 0) ? (64'd1 << m_port) : 64'd0);
            chk("app_req", app_req, m_phase == 1);
            chk("app_req_wr_n", app_req_wr_n, (m_phase == 1) && !m_we);
            chk("app_req_addr", app_req_addr, (m_phase == 1) ? 64'(m_addr >> 2) : 64'd0);
            chk("app_req_len", app_req_len, (m_phase == 1) ? 64'(m_len) : 64'd0);
            chk("wb_ack_o", wb_ack, e_ack);
            chk("wb_dat_o", wb_dat, (m_phase == 3) ? 64'(app_rd_data) : 64'd0);
            chk("app_wr_data", app_wr_data, (m_phase == 2) ? 64'(dat[m_port*DW +: DW]) : 64'd0);
            chk("app_wr_en_n", app_wr_en_n, e_en);
            for (int p = 0; p < NP; p++) ack_cnt[p] += int'(wb_ack[p]);
         end
         // advance the model to what the coming clock edge must produce
         if (rst) begin
            m_phase = 0; m_port = -1; m_last = NP-1; m_left = 0;
         end else if (m_phase == 0) begin
            for (int k = 1; k <= NP; k++) begin
               int q;
               q = (m_last + k) % NP;
               if (m_port < 0 && cyc[q] && stb[q]) begin
                  m_port = q;
                  m_last = q;
                  m_we   = we[q];
                  m_addr = addr[q*26 +: 26];
                  m_len  = (cti[q*3 +: 3] == 3'b010) ? BLEN : 1;
                  m_phase = 1;
               end
            end
         end else if (m_phase == 1) begin
            if (app_req_ack) begin
               m_left  = m_len;
               m_phase = m_we ? 2 : 3;
            end
         end else begin
            if ((m_phase == 2 && app_wr_next_req) || (m_phase == 3 && app_rd_valid)) begin
               m_left--;
               if (m_left == 0 || (m_phase == 3 && app_last_rd)) begin
                  m_phase = 0;
                  m_port  = -1;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_port(input int p, input bit c, input bit w, input logic [25:0] a,
                           input logic [31:0] d, input logic [2:0] t);
      cyc[p] = c; stb[p] = c; we[p] = w;
      addr[p*26 +: 26] = a;
      dat[p*DW +: DW]  = d;
      sel[p*4 +: 4]    = 4'hF;
      cti[p*3 +: 3]    = t;
   endtask

   task automatic drop_all();
      cyc = '0; stb = '0;
   endtask

   task automatic wait_req();
      bit ok;
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         if (app_req) begin
            ok = 1;
            break;
         end
         tick();
      end
      if (!ok) chk("req_timeout", 0, 1);
   endtask

   task automatic accept();
      app_req_ack = 1'b1;
      tick();
      app_req_ack = 1'b0;
   endtask

   int base;

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      tick();
      started = 1;
      tick();
      chk("rst_gnt", gnt, 0);
      chk("rst_req", app_req, 0);
      chk("rst_en_n", app_wr_en_n, 4'hF);
      rst = 1'b0;
      tick();

      // port 0 single write
      base = ack_cnt[0];
      set_port(0, 1, 1, 26'h100, 32'hDEADBEEF, 3'b000);
      wait_req();
      chk("t1_addr", app_req_addr, 25'h40);
      chk("t1_len", app_req_len, 1);
      chk("t1_wr_n", app_req_wr_n, 0);
      chk("t1_gnt", gnt, 4'b0001);
      accept();
      app_wr_next_req = 1'b1;
      #1;
      chk("t1_ack", wb_ack, 4'b0001);
      chk("t1_wdata", app_wr_data, 32'hDEADBEEF);
      tick();
      app_wr_next_req = 1'b0;
      drop_all();
      tick();
      chk("t1_ackcnt", ack_cnt[0] - base, 1);

      // port 2 single read, data three cycles after the accept
      base = ack_cnt[2];
      set_port(2, 1, 0, 26'h2000, 32'h0, 3'b000);
      wait_req();
      chk("t2_gnt", gnt, 4'b0100);
      chk("t2_wr_n", app_req_wr_n, 1);
      accept();
      tick();
      tick();
      app_rd_valid = 1'b1; app_last_rd = 1'b1; app_rd_data = 32'h12345678;
      #1;
      chk("t2_ack", wb_ack, 4'b0100);
      chk("t2_dat", wb_dat, 32'h12345678);
      tick();
      app_rd_valid = 1'b0; app_last_rd = 1'b0;
      drop_all();
      tick();
      chk("t2_ackcnt", ack_cnt[2] - base, 1);
      chk("t2_others", ack_cnt[0] + ack_cnt[1] + ack_cnt[3], 1);

      // all ports contend after a reset: grants 0,1,2,3,0 with one dead cycle each
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int p = 0; p < NP; p++) set_port(p, 1, 1, 26'(p * 16), 32'(p + 32'hA0), 3'b000);
      wait_req();
      for (int n = 0; n < 5; n++) begin
         chk("t3_order", gnt, 4'b0001 << (n % 4));
         accept();
         app_wr_next_req = 1'b1;
         tick();
         app_wr_next_req = 1'b0;
         chk("t3_dead_gnt", gnt, 0);
         chk("t3_dead_req", app_req, 0);
         if (n == 4) drop_all();
         tick();
         if (n < 4) chk("t3_rearb", app_req, 1);
      end

      // port 1 read burst, all strobes
      base = ack_cnt[1];
      set_port(1, 1, 0, 26'h400, 32'h0, 3'b010);
      wait_req();
      chk("t4_len", app_req_len, 8);
      accept();
      for (int b = 1; b <= 8; b++) begin
         app_rd_valid = 1'b1; app_rd_data = 32'(b * 32'h11); app_last_rd = (b == 8);
         tick();
      end
      app_rd_valid = 1'b0; app_last_rd = 1'b0;
      drop_all();
      chk("t4_idle", gnt, 0);
      tick();
      chk("t4_ackcnt", ack_cnt[1] - base, 8);

      // same burst with beats 3-4 unstrobed, counter-terminated
      base = ack_cnt[1];
      set_port(1, 1, 0, 26'h400, 32'h0, 3'b010);
      wait_req();
      accept();
      for (int b = 1; b <= 8; b++) begin
         stb[1] = !(b == 3 || b == 4);
         app_rd_valid = 1'b1; app_rd_data = 32'(b);
         tick();
      end
      app_rd_valid = 1'b0;
      drop_all();
      chk("t4b_idle", gnt, 0);
      chk("t4b_req", app_req, 0);
      tick();
      chk("t4b_ackcnt", ack_cnt[1] - base, 6);

      // burst cut short by app_last_rd on beat 4
      base = ack_cnt[1];
      set_port(1, 1, 0, 26'h800, 32'h0, 3'b010);
      wait_req();
      accept();
      for (int b = 1; b <= 4; b++) begin
         app_rd_valid = 1'b1; app_rd_data = 32'(b + 100); app_last_rd = (b == 4);
         tick();
      end
      app_rd_valid = 1'b0; app_last_rd = 1'b0;
      drop_all();
      chk("t4c_idle", gnt, 0);
      tick();
      chk("t4c_ackcnt", ack_cnt[1] - base, 4);

      // port 3 write burst, beat 5 unstrobed
      base = ack_cnt[3];
      set_port(3, 1, 1, 26'h1000, 32'hCAFE0003, 3'b010);
      wait_req();
      chk("t5_len", app_req_len, 8);
      chk("t5_wr_n", app_req_wr_n, 0);
      accept();
      for (int b = 1; b <= 8; b++) begin
         stb[3] = (b != 5);
         app_wr_next_req = 1'b1;
         #1;
         chk("t5_en_n", app_wr_en_n, (b == 5) ? 4'hF : 4'h0);
         tick();
      end
      app_wr_next_req = 1'b0;
      drop_all();
      tick();
      chk("t5_ackcnt", ack_cnt[3] - base, 7);

      // reset in the middle of a read burst
      set_port(2, 1, 0, 26'h3000, 32'h0, 3'b010);
      wait_req();
      accept();
      for (int b = 1; b <= 3; b++) begin
         app_rd_valid = 1'b1; app_rd_data = 32'(b);
         tick();
      end
      app_rd_valid = 1'b0;
      rst = 1'b1;
      tick();
      chk("t6_gnt", gnt, 0);
      chk("t6_req", app_req, 0);
      chk("t6_en_n", app_wr_en_n, 4'hF);
      rst = 1'b0;
      for (int p = 0; p < NP; p++) set_port(p, 1, 0, 26'(p * 4), 32'h0, 3'b000);
      wait_req();
      chk("t6_first", gnt, 4'b0001);
      accept();
      drop_all();
      app_rd_valid = 1'b1; app_last_rd = 1'b1; app_rd_data = 32'h55AA55AA;
      tick();
      app_rd_valid = 1'b0; app_last_rd = 1'b0;
      tick();
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
